// File: rtl/fma_pkg.sv
// Shared types and constants for the FMA scheduler and its shared serial-load FMA unit.
package fma_pkg;

    typedef logic [31:0] float_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_A,
        S_ISSUE_B,
        S_ISSUE_C,
        S_WAIT,
        S_RECOVER,
        S_RESP,
        S_FAULT
    } sched_state_t;

    localparam float_t FLOAT_ERR = 32'hFFFF_FFFF;

endpackage

// File: rtl/fma_scheduler_if.sv
// Connection between the scheduler (master) and the shared serial-load FMA unit (slave).
interface fma_scheduler_if;
    import fma_pkg::*;

    logic   fma_start;
    float_t fma_float_in;
    float_t fma_float_out;
    logic   fma_ready;
    logic   fma_error;

    modport master (
        output fma_start,
        output fma_float_in,
        input  fma_float_out,
        input  fma_ready,
        input  fma_error
    );

    modport slave (
        input  fma_start,
        input  fma_float_in,
        output fma_float_out,
        output fma_ready,
        output fma_error
    );

endinterface

// File: rtl/fma_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first requester after 'last' (wrapping) wins.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int LW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last,
    output logic [NREQ-1:0] pick,
    output logic            any
);

    localparam int SW = LW + 1;

    logic [SW-1:0] sum;
    logic [LW-1:0] idx;
    logic          found;

    always_comb begin
        pick  = '0;
        any   = |req;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        // k == NREQ lands back on 'last' itself, so it only wins when nobody else asks
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, last} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[LW-1:0];
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fma_scheduler.sv
// Shares one serial-load FMA unit between NREQ requesters: round-robin grant, three-cycle
// operand load, result return with a done pulse, error recovery and a sticky hang timeout.
module fma_scheduler
    import fma_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   op_a,
    input  logic [NREQ*32-1:0]   op_b,
    input  logic [NREQ*32-1:0]   op_c,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output float_t               result,
    output logic                 result_err,
    output logic                 busy,
    output logic                 fault,
    fma_scheduler_if.master      fma
);

    localparam int LW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    sched_state_t    state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [LW-1:0]   last_q, last_d;
    float_t          result_q, result_d;
    logic            result_err_q, result_err_d;
    logic            fault_q, fault_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            rec_q, rec_d;

    logic [NREQ-1:0] pick;
    logic            any;
    float_t          sel_a, sel_b, sel_c;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req  (req),
        .last (last_q),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                sel_a = op_a[32*i +: 32];
                sel_b = op_b[32*i +: 32];
                sel_c = op_c[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_d           = last_q;
        result_d         = result_q;
        result_err_d     = result_err_q;
        fault_d          = fault_q;
        tmo_d            = tmo_q;
        rec_d            = rec_q;
        done             = '0;
        fma.fma_start    = 1'b0;
        fma.fma_float_in = '0;

        case (state_q)
            S_IDLE: begin
                if (any) begin
                    grant_d = pick;
                    state_d = S_ISSUE_A;
                end
            end
            S_ISSUE_A: begin
                fma.fma_start    = 1'b1;
                fma.fma_float_in = sel_a;
                rec_d            = 1'b0;
                state_d          = fma.fma_error ? S_RECOVER : S_ISSUE_B;
            end
            S_ISSUE_B: begin
                fma.fma_float_in = sel_b;
                rec_d            = 1'b0;
                state_d          = fma.fma_error ? S_RECOVER : S_ISSUE_C;
            end
            S_ISSUE_C: begin
                fma.fma_float_in = sel_c;
                rec_d            = 1'b0;
                tmo_d            = '0;
                state_d          = fma.fma_error ? S_RECOVER : S_WAIT;
            end
            S_WAIT: begin
                // Holding c keeps the unit's exponent check quiet while it multiplies
                fma.fma_float_in = sel_c;
                tmo_d            = tmo_q + 1'b1;
                if (fma.fma_ready) begin
                    result_d     = fma.fma_float_out;
                    result_err_d = 1'b0;
                    state_d      = S_RESP;
                end else if (tmo_d == TW'(TIMEOUT)) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end
            end
            S_RECOVER: begin
                rec_d = 1'b1;
                if (rec_q) begin
                    result_d     = FLOAT_ERR;
                    result_err_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                done = grant_q;
                for (int i = 0; i < NREQ; i++) begin
                    if (grant_q[i]) begin
                        last_d = LW'(i);
                    end
                end
                grant_d = '0;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_q       <= LW'(NREQ - 1);
            result_q     <= '0;
            result_err_q <= 1'b0;
            fault_q      <= 1'b0;
            tmo_q        <= '0;
            rec_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            result_q     <= result_d;
            result_err_q <= result_err_d;
            fault_q      <= fault_d;
            tmo_q        <= tmo_d;
            rec_q        <= rec_d;
        end
    end

    assign grant      = grant_q;
    assign result     = result_q;
    assign result_err = result_err_q;
    assign fault      = fault_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fma_scheduler.sv
// Directed bench for fma_scheduler: two instances (TIMEOUT 64 and 8), each with a behavioral FMA unit.
module tb_fma_scheduler;

    localparam int NREQ = 4;
    localparam logic [2:0] M_IDLE = 3'd0;
    localparam logic [2:0] M_LB   = 3'd1;
    localparam logic [2:0] M_LC   = 3'd2;
    localparam logic [2:0] M_MUL  = 3'd3;
    localparam logic [2:0] M_ERR  = 3'd4;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*32-1:0]  op_a, op_b, op_c;
    int                  mdl_w;
    logic                mdl_hang;
    logic                inj_rdy;
    logic [31:0]         mdl_out;

    logic [NREQ-1:0] grant_w [2];
    logic [NREQ-1:0] done_w  [2];
    logic [31:0]     result_w[2];
    logic            rerr_w  [2];
    logic            busy_w  [2];
    logic            fault_w [2];
    logic            start_w [2];
    logic [31:0]     fin_w   [2];
    logic [2:0]      ph_w    [2];
    logic [31:0]     ca_w    [2];
    logic [31:0]     cb_w    [2];
    logic [31:0]     cc_w    [2];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        fma_scheduler_if u_if ();

        logic [2:0]  ph_q;
        logic [7:0]  cnt_q;
        logic [31:0] ca_q, cb_q, cc_q;
        logic        m_err, m_rdy;

        fma_scheduler #(.NREQ(NREQ), .TIMEOUT(k == 0 ? 64 : 8)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req        (req),
            .op_a       (op_a),
            .op_b       (op_b),
            .op_c       (op_c),
            .grant      (grant_w[k]),
            .done       (done_w[k]),
            .result     (result_w[k]),
            .result_err (rerr_w[k]),
            .busy       (busy_w[k]),
            .fault      (fault_w[k]),
            .fma        (u_if)
        );

        // Unit model: loads a,b,c on consecutive cycles after start, ready on the W-th multiply cycle
        always_comb begin
            m_err = (ph_q != M_ERR) && ((ph_q != M_IDLE) || u_if.fma_start)
                    && (u_if.fma_float_in[30:23] == 8'h00);
            m_rdy = (ph_q == M_MUL) && (cnt_q == mdl_w[7:0]) && !mdl_hang;
        end

        assign u_if.fma_error     = m_err;
        assign u_if.fma_ready     = m_rdy | inj_rdy;
        assign u_if.fma_float_out = mdl_out;

        always_ff @(posedge clk) begin
            if (rst) begin
                ph_q  <= M_IDLE;
                cnt_q <= '0;
            end else begin
                case (ph_q)
                    M_IDLE: if (u_if.fma_start) begin
                        if (m_err) ph_q <= M_ERR;
                        else begin ca_q <= u_if.fma_float_in; ph_q <= M_LB; end
                    end
                    M_LB: begin
                        if (m_err) ph_q <= M_ERR;
                        else begin cb_q <= u_if.fma_float_in; ph_q <= M_LC; end
                    end
                    M_LC: begin
                        if (m_err) ph_q <= M_ERR;
                        else begin cc_q <= u_if.fma_float_in; cnt_q <= 8'd1; ph_q <= M_MUL; end
                    end
                    M_MUL: begin
                        if (m_rdy) ph_q <= M_IDLE;
                        else cnt_q <= cnt_q + 8'd1;
                    end
                    default: ph_q <= M_IDLE;
                endcase
            end
        end

        assign start_w[k] = u_if.fma_start;
        assign fin_w[k]   = u_if.fma_float_in;
        assign ph_w[k]    = ph_q;
        assign ca_w[k]    = ca_q;
        assign cb_w[k]    = cb_q;
        assign cc_w[k]    = cc_q;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_start(input int k, output int ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (start_w[k]) begin
                ok = 1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_done(input int k, input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            n++;
            if (done_w[k] != '0) return;
        end
        n = -1;
    endtask

    task automatic check_reset_vals(input int k, input string tag);
        check_eq({tag, "_grant"},  32'(grant_w[k]),  32'h0);
        check_eq({tag, "_done"},   32'(done_w[k]),   32'h0);
        check_eq({tag, "_busy"},   32'(busy_w[k]),   32'h0);
        check_eq({tag, "_fault"},  32'(fault_w[k]),  32'h0);
        check_eq({tag, "_rerr"},   32'(rerr_w[k]),   32'h0);
        check_eq({tag, "_result"}, result_w[k],      32'h0);
        check_eq({tag, "_start"},  32'(start_w[k]),  32'h0);
        check_eq({tag, "_fin"},    fin_w[k],         32'h0);
    endtask

    // Every start must find the unit idle
    always @(negedge clk) begin
        if (!rst && start_w[0]) check_eq("unit_idle_at_start", 32'(ph_w[0]), 32'(M_IDLE));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ok, cnt;
        int order [5] = '{0, 1, 2, 3, 0};

        rst = 1'b1; req = '0; op_a = '0; op_b = '0; op_c = '0;
        mdl_w = 25; mdl_hang = 1'b0; inj_rdy = 1'b0; mdl_out = '0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_vals(0, "rst0");

        // Single request, W=25
        mdl_out = 32'h41D2_0000;
        op_a[31:0] = 32'h4128_0000;
        op_b[31:0] = 32'h4020_0000;
        op_c[31:0] = 32'h400C_CCCD;
        req = 4'b0001;
        tick();
        check_eq("t1_start_a", 32'(start_w[0]), 32'h1);
        check_eq("t1_fin_a",   fin_w[0],        32'h4128_0000);
        check_eq("t1_grant",   32'(grant_w[0]), 32'h1);
        check_eq("t1_busy",    32'(busy_w[0]),  32'h1);
        tick();
        check_eq("t1_start_b", 32'(start_w[0]), 32'h0);
        check_eq("t1_fin_b",   fin_w[0],        32'h4020_0000);
        tick();
        check_eq("t1_fin_c",   fin_w[0],        32'h400C_CCCD);
        wait_done(0, 60, n);
        check_eq("t1_latency", 32'(n),          32'd26);
        check_eq("t1_done",    32'(done_w[0]),  32'h1);
        check_eq("t1_result",  result_w[0],     32'h41D2_0000);
        check_eq("t1_rerr",    32'(rerr_w[0]),  32'h0);
        check_eq("t1_cap_a",   ca_w[0],         32'h4128_0000);
        check_eq("t1_cap_b",   cb_w[0],         32'h4020_0000);
        check_eq("t1_cap_c",   cc_w[0],         32'h400C_CCCD);
        req = '0;
        tick();
        check_eq("t1_done_pulse", 32'(done_w[0]),  32'h0);
        check_eq("t1_grant_clr",  32'(grant_w[0]), 32'h0);

        // All four requesting continuously
        do_reset();
        mdl_w = 3;
        mdl_out = 32'h3F80_0000;
        for (int i = 0; i < NREQ; i++) begin
            op_a[32*i +: 32] = 32'h4000_0000 + 32'(i);
            op_b[32*i +: 32] = 32'h4040_0000;
            op_c[32*i +: 32] = 32'h3F80_0000;
        end
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_done(0, 30, n);
            check_eq("t2_order", 32'(done_w[0]), 32'(1) << order[t]);
            check_eq("t2_rerr",  32'(rerr_w[0]), 32'h0);
        end
        req = '0;
        tick();
        tick();

        // Requester 2 with b = 0.0 trips the unit's error check in ISSUE_B
        do_reset();
        op_b[32*2 +: 32] = 32'h0000_0000;
        req = 4'b0100;
        wait_start(0, ok);
        check_eq("t3_start_seen", 32'(ok), 32'h1);
        check_eq("t3_grant",      32'(grant_w[0]), 32'h4);
        wait_done(0, 10, n);
        check_eq("t3_latency", 32'(n),          32'd4);
        check_eq("t3_done",    32'(done_w[0]),  32'h4);
        check_eq("t3_result",  result_w[0],     32'hFFFF_FFFF);
        check_eq("t3_rerr",    32'(rerr_w[0]),  32'h1);
        op_b[32*2 +: 32] = 32'h4040_0000;
        mdl_out = 32'h4110_0000;
        req = 4'b0010;
        wait_done(0, 30, n);
        check_eq("t3_next_done",   32'(done_w[0]), 32'h2);
        check_eq("t3_next_result", result_w[0],    32'h4110_0000);
        check_eq("t3_next_rerr",   32'(rerr_w[0]), 32'h0);
        req = '0;
        tick();

        // Unit hangs; the TIMEOUT=8 instance must fault after 8 WAIT cycles
        do_reset();
        mdl_hang = 1'b1;
        req = 4'b0001;
        wait_start(1, ok);
        check_eq("t4_start_seen", 32'(ok), 32'h1);
        for (int j = 0; j < 10; j++) tick();
        check_eq("t4_no_fault_yet", 32'(fault_w[1]), 32'h0);
        tick();
        check_eq("t4_fault",  32'(fault_w[1]), 32'h1);
        check_eq("t4_busy",   32'(busy_w[1]),  32'h1);
        check_eq("t4_start0", 32'(start_w[1]), 32'h0);
        check_eq("t4_fin0",   fin_w[1],        32'h0);
        req = '0;
        cnt = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (fault_w[1] && busy_w[1] && (done_w[1] == '0)) cnt++;
        end
        check_eq("t4_sticky", 32'(cnt), 32'd20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_hang = 1'b0;
        check_reset_vals(1, "t4_rst");

        // Reset in the middle of requester 1's WAIT
        do_reset();
        mdl_w = 10;
        mdl_out = 32'h4100_0000;
        req = 4'b0010;
        wait_start(0, ok);
        check_eq("t5_start_seen", 32'(ok), 32'h1);
        for (int j = 0; j < 5; j++) tick();
        check_eq("t5_in_wait", 32'(busy_w[0]), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5_idle",  32'(busy_w[0]),  32'h0);
        check_eq("t5_grant", 32'(grant_w[0]), 32'h0);
        check_eq("t5_nodone", 32'(done_w[0]), 32'h0);
        wait_done(0, 40, n);
        check_eq("t5_latency", 32'(n),         32'd14);
        check_eq("t5_done",    32'(done_w[0]), 32'h2);
        check_eq("t5_result",  result_w[0],    32'h4100_0000);
        req = '0;
        tick();

        // Spurious ready pulses in IDLE and ISSUE are ignored
        do_reset();
        mdl_w = 6;
        mdl_out = 32'h4228_0000;
        inj_rdy = 1'b1;
        tick();
        inj_rdy = 1'b0;
        check_eq("t6_idle_result", result_w[0],    32'h0);
        check_eq("t6_idle_busy",   32'(busy_w[0]), 32'h0);
        req = 4'b0001;
        tick();
        inj_rdy = 1'b1;
        tick();
        check_eq("t6_fin_b",      fin_w[0],    32'h4040_0000);
        check_eq("t6_iss_result", result_w[0], 32'h0);
        tick();
        inj_rdy = 1'b0;
        check_eq("t6_fin_c",   fin_w[0],        32'h3F80_0000);
        check_eq("t6_no_done", 32'(done_w[0]),  32'h0);
        wait_done(0, 30, n);
        check_eq("t6_latency", 32'(n),          32'd7);
        check_eq("t6_done",    32'(done_w[0]),  32'h1);
        check_eq("t6_result",  result_w[0],     32'h4228_0000);
        check_eq("t6_rerr",    32'(rerr_w[0]),  32'h0);
        req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
